// File: rtl/bin_to_ascii_bcd.sv
// bin_to_ascii_bcd
//   Sequential binary to four-digit decimal ASCII converter. Uses shift-and-add-3
//   (double dabble), one input bit per clock. Inputs above 9999 saturate to 9999.
//
// Ports
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   bin_in      : unsigned binary value, sampled on the start edge
//   cross_ready : request level, held high until bcd_ready is seen
//   ascii_out   : four ASCII digits, thousands in [31:24] .. units in [7:0]
//   bcd_ready   : conversion done level, held while cross_ready stays high
//
// Build option
//   BCD_LEADING_BLANK_EN : when defined, leading zero digits (except units)
//                          are output as spaces (8'h20).
module bin_to_ascii_bcd #(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             cross_ready,
  output logic [31:0]      ascii_out,
  output logic             bcd_ready
);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  localparam int unsigned     CNT_W   = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] SAT_VAL = BIN_W'(9999);
`ifdef BCD_LEADING_BLANK_EN
  localparam logic [31:0]     ASCII_RST = 32'h20202030;
`else
  localparam logic [31:0]     ASCII_RST = 32'h30303030;
`endif

  state_t           state_q;
  logic [BIN_W-1:0] bin_q;
  logic [15:0]      bcd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      ascii_q;
  logic             ready_q;

  logic [BIN_W-1:0] bin_sat_d;
  logic [15:0]      bcd_adj;
  logic [15:0]      bcd_d;
  logic [31:0]      ascii_d;

  assign ascii_out = ascii_q;
  assign bcd_ready = ready_q;

  // Input saturation at the start edge.
  always_comb begin
    bin_sat_d = bin_in;
    if (32'(bin_in) > 32'd9999) bin_sat_d = SAT_VAL;
  end

  // One double-dabble step: add 3 to any nibble >= 5, then shift in the next bit.
  // ascii_d maps the post-shift value so the final step lands in ascii_q directly.
  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
    bcd_d = {bcd_adj[14:0], bin_q[BIN_W-1]};

    ascii_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      ascii_d[8*i +: 8] = {4'h3, bcd_d[4*i +: 4]};
    end
`ifdef BCD_LEADING_BLANK_EN
    if (bcd_d[15:12] == 4'd0) ascii_d[31:24] = 8'h20;
    if (bcd_d[15:8]  == 8'd0) ascii_d[23:16] = 8'h20;
    if (bcd_d[15:4]  == 12'd0) ascii_d[15:8] = 8'h20;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ascii_q <= ASCII_RST;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (cross_ready) begin
            bin_q   <= bin_sat_d;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          // Abort wins over completion; ascii_q and ready_q are left untouched.
          if (!cross_ready) begin
            state_q <= IDLE;
          end else begin
            bcd_q <= bcd_d;
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
              ascii_q <= ascii_d;
              ready_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (!cross_ready) begin
            ready_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_ascii_bcd.sv
module tb_bin_to_ascii_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] bin_in;
  logic        cross_ready;
  logic [31:0] ascii_out;
  logic        bcd_ready;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] last_exp;

`ifdef BCD_LEADING_BLANK_EN
  localparam logic [31:0] RST_VAL = 32'h20202030;
`else
  localparam logic [31:0] RST_VAL = 32'h30303030;
`endif

  always #5 clk = ~clk;

  bin_to_ascii_bcd #(.BIN_W(14)) dut (
    .clk         (clk),
    .rst         (rst),
    .bin_in      (bin_in),
    .cross_ready (cross_ready),
    .ascii_out   (ascii_out),
    .bcd_ready   (bcd_ready)
  );

  // Reference: decimal digits by division, saturating at 9999.
  function automatic logic [31:0] model(input int unsigned x);
    int unsigned v;
    logic [7:0]  d3, d2, d1, d0;
    v  = (x > 9999) ? 9999 : x;
    d3 = 8'(48 + v / 1000);
    d2 = 8'(48 + (v / 100) % 10);
    d1 = 8'(48 + (v / 10) % 10);
    d0 = 8'(48 + v % 10);
`ifdef BCD_LEADING_BLANK_EN
    if (v < 1000) d3 = 8'h20;
    if (v < 100)  d2 = 8'h20;
    if (v < 10)   d1 = 8'h20;
`endif
    return {d3, d2, d1, d0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full handshake for one value; optionally disturbs bin_in mid-conversion.
  task automatic run_conv(input int unsigned v, input bit scramble, input string name);
    int unsigned edges;
    bit          seen;
    logic [31:0] exp;
    exp         = model(v);
    bin_in      = 14'(v);
    cross_ready = 1'b1;
    edges       = 0;
    seen        = 1'b0;
    while (!seen && edges < 40) begin
      step();
      edges++;
      if (scramble && edges == 5) bin_in = 14'($urandom);
      if (bcd_ready === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen || edges != 15) begin
      miscompares++;
      $display("FAIL %s latency: got %0d edges (seen=%0d) want 15", name, edges, seen);
    end
    vectors++;
    if (ascii_out !== exp) begin
      miscompares++;
      $display("FAIL %s ascii: got %h want %h", name, ascii_out, exp);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (bcd_ready !== 1'b1 || ascii_out !== exp) begin
        miscompares++;
        $display("FAIL %s hold: got ready=%b ascii=%h want ready=1 ascii=%h", name, bcd_ready, ascii_out, exp);
      end
    end
    cross_ready = 1'b0;
    bin_in      = 14'($urandom);
    step();
    vectors++;
    if (bcd_ready !== 1'b0 || ascii_out !== exp) begin
      miscompares++;
      $display("FAIL %s release: got ready=%b ascii=%h want ready=0 ascii=%h", name, bcd_ready, ascii_out, exp);
    end
    last_exp = exp;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    cross_ready = 1'b0;
    bin_in      = '0;
    #12;
    vectors++;
    if (ascii_out !== RST_VAL || bcd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got ready=%b ascii=%h want ready=0 ascii=%h", bcd_ready, ascii_out, RST_VAL);
    end
    step();
    rst = 1'b0;
    last_exp = RST_VAL;
  endtask

  task automatic test_basic();
    run_conv(25, 1'b0, "v25");
    run_conv(9999, 1'b0, "v9999");
    run_conv(0, 1'b0, "v0");
    run_conv(16383, 1'b0, "sat16383");
    run_conv(10000, 1'b0, "sat10000");
    run_conv(7, 1'b0, "v7");
    run_conv(305, 1'b0, "v305");
  endtask

  task automatic test_abort();
    bin_in      = 14'd1234;
    cross_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    cross_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if (bcd_ready !== 1'b0 || ascii_out !== last_exp) begin
        miscompares++;
        $display("FAIL abort: got ready=%b ascii=%h want ready=0 ascii=%h", bcd_ready, ascii_out, last_exp);
      end
    end
    run_conv(1234, 1'b0, "rerequest1234");
  endtask

  task automatic test_back_to_back();
    run_conv(58, 1'b1, "b2b58");
    run_conv(4096, 1'b1, "b2b4096");
  endtask

  task automatic test_reset_mid();
    run_conv(9876, 1'b0, "pre_reset");
    bin_in      = 14'd4321;
    cross_ready = 1'b1;
    while (bcd_ready !== 1'b1 && vectors < 100000) begin
      step();
      if (bcd_ready !== 1'b1 && $time > 5_000_000) break;
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bcd_ready !== 1'b0 || ascii_out !== RST_VAL) begin
      miscompares++;
      $display("FAIL reset_mid: got ready=%b ascii=%h want ready=0 ascii=%h", bcd_ready, ascii_out, RST_VAL);
    end
    cross_ready = 1'b0;
    step();
    rst = 1'b0;
    last_exp = RST_VAL;
    run_conv(42, 1'b0, "post_reset42");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_conv((i % 4 == 0) ? $urandom_range(9990, 16383) : $urandom_range(0, 9999), 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
